// File: rtl/i2s_clk_gen_pkg.sv
// Shared types and helpers for the I2S/TDM bit-clock and frame-timing generator.
// The config struct uses fixed widths wide enough for any legal DIV_W (<= 16) and CH_MAX (<= 16).
package i2s_clk_gen_pkg;

    localparam int CFG_DIV_W   = 16;
    localparam int CFG_SLOTS_W = 5;

    localparam logic [5:0] MIN_SLOT_BITS = 6'd8;
    localparam logic [5:0] MAX_SLOT_BITS = 6'd32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } clkgen_state_t;

    typedef struct packed {
        logic [CFG_DIV_W-1:0]   div;
        logic [5:0]             slot_bits;
        logic [CFG_SLOTS_W-1:0] slots;
    } clkgen_cfg_t;

    // Force an offered config into the range the timing counters can run.
    function automatic clkgen_cfg_t clamp_cfg(input clkgen_cfg_t raw,
                                              input logic [CFG_SLOTS_W-1:0] ch_max);
        clkgen_cfg_t c;
        c = raw;
        if (raw.div == '0)
            c.div = CFG_DIV_W'(1);
        if (raw.slot_bits < MIN_SLOT_BITS)
            c.slot_bits = MIN_SLOT_BITS;
        else if (raw.slot_bits > MAX_SLOT_BITS)
            c.slot_bits = MAX_SLOT_BITS;
        if (raw.slots < CFG_SLOTS_W'(2))
            c.slots = CFG_SLOTS_W'(2);
        else if (raw.slots > ch_max)
            c.slots = ch_max;
        else if (raw.slots[0])
            c.slots = raw.slots + CFG_SLOTS_W'(1);
        return c;
    endfunction

endpackage

// File: rtl/i2s_clk_gen_if.sv
// Config handshake and timing outputs of i2s_clk_gen; mclk/rst_ stay plain ports.
interface i2s_clk_gen_if #(
    parameter int DIV_W  = 8,
    parameter int CH_MAX = 8
);
    localparam int CH_W = $clog2(CH_MAX) + 1;

    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div;
    logic [5:0]       cfg_slot_bits;
    logic [CH_W-1:0]  cfg_slots;
    logic             sclk;
    logic             ws;
    logic             sclk_rise;
    logic             sclk_fall;
    logic             frame_start;
    logic [CH_W-1:0]  slot_idx;
    logic [4:0]       bit_idx;
    logic             busy;

    modport master (
        output en, cfg_valid, cfg_div, cfg_slot_bits, cfg_slots,
        input  cfg_ready, sclk, ws, sclk_rise, sclk_fall, frame_start,
               slot_idx, bit_idx, busy
    );

    modport slave (
        input  en, cfg_valid, cfg_div, cfg_slot_bits, cfg_slots,
        output cfg_ready, sclk, ws, sclk_rise, sclk_fall, frame_start,
               slot_idx, bit_idx, busy
    );

endinterface

// File: rtl/i2s_clk_gen_cfg_shadow.sv
// Config shadow register: clamps and holds one accepted config until the
// generator signals a safe point (idle or frame start) to make it active.
module clkgen_cfg_shadow
    import i2s_clk_gen_pkg::*;
#(
    parameter int CH_MAX        = 8,
    parameter int DEF_DIV       = 4,
    parameter int DEF_SLOT_BITS = 32,
    parameter int DEF_SLOTS     = 2
) (
    input  logic        mclk,
    input  logic        rst_,
    input  logic        cfg_valid,
    input  clkgen_cfg_t cfg_raw,
    input  logic        apply,
    output clkgen_cfg_t active,
    output logic        cfg_ready
);

    localparam clkgen_cfg_t DEF_CFG = '{
        div:       CFG_DIV_W'(DEF_DIV),
        slot_bits: 6'(DEF_SLOT_BITS),
        slots:     CFG_SLOTS_W'(DEF_SLOTS)
    };

    clkgen_cfg_t shadow;
    logic        pending;

    // Accept and apply are exclusive: a new offer is only taken when nothing is pending.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge mclk or negedge rst_) begin
        if (!rst_) begin
            active  <= DEF_CFG;
            shadow  <= DEF_CFG;
            pending <= 1'b0;
        end else if (apply && pending) begin
            active  <= shadow;
            pending <= 1'b0;
        end else if (cfg_valid && !pending) begin
            shadow  <= clamp_cfg(cfg_raw, CFG_SLOTS_W'(CH_MAX));
            pending <= 1'b1;
        end
    end

    assign cfg_ready = !pending;

endmodule

// File: rtl/i2s_clk_gen.sv
// I2S/TDM bit-clock and frame-timing generator with frame-boundary config updates.
// Define I2S_CLK_GEN_DSP_WS_EN for a one-bit frame-sync ws instead of the half-frame ws.
module i2s_clk_gen
    import i2s_clk_gen_pkg::*;
#(
    parameter int DIV_W         = 8,
    parameter int CH_MAX        = 8,
    parameter int DEF_DIV       = 4,
    parameter int DEF_SLOT_BITS = 32,
    parameter int DEF_SLOTS     = 2
) (
    input logic          mclk,
    input logic          rst_,
    i2s_clk_gen_if.slave bus
);

    localparam int CH_W = $clog2(CH_MAX) + 1;

    clkgen_state_t    state, state_nx;
    logic [DIV_W-1:0] hc, hc_nx;
    logic             sclk, sclk_nx;
    logic             ws, ws_nx;
    logic             sclk_rise, rise_nx;
    logic             sclk_fall, fall_nx;
    logic             frame_start, fs_nx;
    logic [4:0]       bit_idx, bit_nx;
    logic [CH_W-1:0]  slot_idx, slot_nx;

    clkgen_cfg_t cfg_raw, active;
    logic        apply, tick, last_bit, last_slot;

    assign cfg_raw = '{
        div:       CFG_DIV_W'(bus.cfg_div),
        slot_bits: bus.cfg_slot_bits,
        slots:     CFG_SLOTS_W'(bus.cfg_slots)
    };

    // A pending config is applied while idle or on the edge that opens a new frame.
    assign apply = (state == IDLE) || fs_nx;

    clkgen_cfg_shadow #(
        .CH_MAX        (CH_MAX),
        .DEF_DIV       (DEF_DIV),
        .DEF_SLOT_BITS (DEF_SLOT_BITS),
        .DEF_SLOTS     (DEF_SLOTS)
    ) u_shadow (
        .mclk      (mclk),
        .rst_      (rst_),
        .cfg_valid (bus.cfg_valid),
        .cfg_raw   (cfg_raw),
        .apply     (apply),
        .active    (active),
        .cfg_ready (bus.cfg_ready)
    );

    assign tick      = (CFG_DIV_W'(hc) == active.div - CFG_DIV_W'(1));
    assign last_bit  = (6'(bit_idx) == active.slot_bits - 6'd1);
    assign last_slot = (CFG_SLOTS_W'(slot_idx) == active.slots - CFG_SLOTS_W'(1));

    // NOTE: every variable gets a default first so this block stays purely combinational.
    always_comb begin
        state_nx = state;
        hc_nx    = hc;
        sclk_nx  = sclk;
        ws_nx    = ws;
        bit_nx   = bit_idx;
        slot_nx  = slot_idx;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        fs_nx    = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.en) begin
                    state_nx = RUN;
                    hc_nx    = '0;
                    sclk_nx  = 1'b0;
                    ws_nx    = 1'b0;
                    bit_nx   = '0;
                    slot_nx  = '0;
                    fs_nx    = 1'b1;
                end
            end
            default: begin
                if (state == RUN && !bus.en)
                    state_nx = STOP;
                else if (state == STOP && bus.en)
                    state_nx = RUN;

                if (!tick) begin
                    hc_nx = hc + DIV_W'(1);
                end else begin
                    hc_nx   = '0;
                    sclk_nx = !sclk;
                    rise_nx = !sclk;
                    fall_nx = sclk;
                    // Position advances only on the falling half of the bit clock.
                    if (sclk) begin
                        if (last_bit) begin
                            bit_nx  = '0;
                            slot_nx = last_slot ? '0 : slot_idx + CH_W'(1);
                        end else begin
                            bit_nx = bit_idx + 5'd1;
                        end
`ifdef I2S_CLK_GEN_DSP_WS_EN
                        ws_nx = (CFG_SLOTS_W'(slot_nx) == active.slots - CFG_SLOTS_W'(1)) &&
                                (6'(bit_nx) == active.slot_bits - 6'd1);
`else
                        ws_nx = (CFG_SLOTS_W'(slot_nx) >= (active.slots >> 1));
`endif
                        if (last_bit && last_slot) begin
                            if (state == STOP && !bus.en)
                                state_nx = IDLE;
                            else
                                fs_nx = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge mclk or negedge rst_) begin
        if (!rst_) begin
            state       <= IDLE;
            hc          <= '0;
            sclk        <= 1'b0;
            ws          <= 1'b0;
            sclk_rise   <= 1'b0;
            sclk_fall   <= 1'b0;
            frame_start <= 1'b0;
            bit_idx     <= '0;
            slot_idx    <= '0;
        end else begin
            state       <= state_nx;
            hc          <= hc_nx;
            sclk        <= sclk_nx;
            ws          <= ws_nx;
            sclk_rise   <= rise_nx;
            sclk_fall   <= fall_nx;
            frame_start <= fs_nx;
            bit_idx     <= bit_nx;
            slot_idx    <= slot_nx;
        end
    end

    assign bus.sclk        = sclk;
    assign bus.ws          = ws;
    assign bus.sclk_rise   = sclk_rise;
    assign bus.sclk_fall   = sclk_fall;
    assign bus.frame_start = frame_start;
    assign bus.bit_idx     = bit_idx;
    assign bus.slot_idx    = slot_idx;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_i2s_clk_gen.sv
// Bench for i2s_clk_gen: a frame-position reference model predicts every output each cycle
// while directed scenarios and a randomized phase exercise config, stop/restart and reset.
module tb_i2s_clk_gen;

    localparam int CH_MAX = 8;

    logic mclk = 1'b0;
    logic rst_ = 1'b0;

    always #5 mclk = ~mclk;

    i2s_clk_gen_if #(.DIV_W(8), .CH_MAX(CH_MAX)) bus ();

    i2s_clk_gen dut (
        .mclk (mclk),
        .rst_ (rst_),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a running flag plus the mclk position inside the current frame.
    int a_div, a_bits, a_slots;
    int s_div, s_bits, s_slots;
    bit m_pend, m_run, m_stop, m_prev_sclk;
    int m_p;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic void clamp(input int d, input int b, input int s,
                                  output int od, output int ob, output int os);
        od = (d == 0) ? 1 : d;
        ob = (b < 8) ? 8 : ((b > 32) ? 32 : b);
        if (s < 2)            os = 2;
        else if (s > CH_MAX)  os = CH_MAX;
        else if (s % 2 == 1)  os = s + 1;
        else                  os = s;
    endfunction

    function automatic void model_reset();
        a_div = 4; a_bits = 32; a_slots = 2;
        s_div = 4; s_bits = 32; s_slots = 2;
        m_pend = 0; m_run = 0; m_stop = 0; m_prev_sclk = 0; m_p = 0;
    endfunction

    function automatic bit exp_sclk();
        return m_run ? bit'((m_p / a_div) % 2) : 1'b0;
    endfunction

    function automatic void model_edge();
        bit acc;
        int len;
        acc = bus.cfg_valid && !m_pend;
        len = 2 * a_div * a_bits * a_slots;
        m_prev_sclk = exp_sclk();
        if (!m_run) begin
            if (m_pend) begin
                a_div = s_div; a_bits = s_bits; a_slots = s_slots; m_pend = 0;
            end
            if (bus.en) begin
                m_run = 1; m_p = 0;
            end
            m_stop = 0;
        end else if (m_p == len - 1) begin
            if (m_stop && !bus.en) begin
                m_run = 0; m_p = 0;
            end else begin
                m_p = 0;
                if (m_pend) begin
                    a_div = s_div; a_bits = s_bits; a_slots = s_slots; m_pend = 0;
                end
            end
            m_stop = !bus.en;
        end else begin
            m_p++;
            m_stop = !bus.en;
        end
        if (acc) begin
            clamp(int'(bus.cfg_div), int'(bus.cfg_slot_bits), int'(bus.cfg_slots),
                  s_div, s_bits, s_slots);
            m_pend = 1;
        end
    endfunction

    task automatic compare_all();
        int sc, bi, sl, w;
        sc = 0; bi = 0; sl = 0; w = 0;
        if (m_run) begin
            sc = (m_p / a_div) % 2;
            bi = (m_p / (2 * a_div)) % a_bits;
            sl = m_p / (2 * a_div * a_bits);
`ifdef I2S_CLK_GEN_DSP_WS_EN
            w = (sl == a_slots - 1 && bi == a_bits - 1) ? 1 : 0;
`else
            w = (sl >= a_slots / 2) ? 1 : 0;
`endif
        end
        check("busy",        bus.busy,        m_run);
        check("sclk",        bus.sclk,        sc);
        check("ws",          bus.ws,          w);
        check("sclk_rise",   bus.sclk_rise,   (sc == 1 && !m_prev_sclk));
        check("sclk_fall",   bus.sclk_fall,   (sc == 0 && m_prev_sclk));
        check("frame_start", bus.frame_start, (m_run && m_p == 0));
        check("slot_idx",    bus.slot_idx,    sl);
        check("bit_idx",     bus.bit_idx,     bi);
        check("cfg_ready",   bus.cfg_ready,   !m_pend);
    endtask

    task automatic step();
        @(posedge mclk);
        model_edge();
        @(negedge mclk);
        compare_all();
    endtask

    task automatic offer(input int d, input int b, input int s);
        bus.cfg_valid     = 1'b1;
        bus.cfg_div       = 8'(d);
        bus.cfg_slot_bits = 6'(b);
        bus.cfg_slots     = 4'(s);
        step();
        bus.cfg_valid     = 1'b0;
    endtask

    task automatic run_to(input int p);
        int n = 0;
        do begin step(); n++; end while (!(m_run && m_p == p) && n < 5000);
        check("run_to", m_p, p);
    endtask

    task automatic measure_frame(input string tag, input int exp_len);
        int n = 0;
        do begin step(); n++; end while (!bus.frame_start && n < 5000);
        check({tag, "_sync"}, bus.frame_start, 1);
        n = 0;
        do begin step(); n++; end while (!bus.frame_start && n < 5000);
        check(tag, n, exp_len);
    endtask

    initial begin
        int n;
        model_reset();
        bus.en = 1'b0; bus.cfg_valid = 1'b0;
        bus.cfg_div = '0; bus.cfg_slot_bits = '0; bus.cfg_slots = '0;
        repeat (3) @(negedge mclk);
        compare_all();
        rst_ = 1'b1;

        // Baseline I2S stereo: div 2, 16-bit slots.
        offer(2, 16, 2);
        step();
        bus.en = 1'b1;
        measure_frame("base_frame", 128);

        // Mid-frame reconfig to div 3 only takes effect at the next frame.
        run_to(40);
        offer(3, 16, 2);
        check("ready_drop", bus.cfg_ready, 0);
        run_to(0);
        check("ready_back", bus.cfg_ready, 1);
        measure_frame("reconf_frame", 192);
        run_to(10);
        offer(2, 16, 2);
        run_to(0);

        // Stop request mid-frame drains to the boundary, then idles.
        run_to(50);
        bus.en = 1'b0;
        n = 0;
        do begin step(); n++; end while (bus.busy && n < 500);
        check("stop_drain", n, 78);
        repeat (5) step();
        bus.en = 1'b1;

        // Stop withdrawn before the boundary: frames continue back to back.
        run_to(50);
        bus.en = 1'b0;
        run_to(90);
        bus.en = 1'b1;
        run_to(0);
        check("no_gap_fs", bus.frame_start, 1);
        check("no_gap_busy", bus.busy, 1);

        // TDM eight slots.
        run_to(5);
        offer(1, 32, 8);
        measure_frame("tdm_frame", 512);

        // Out-of-range request clamps to div 1, 32 bits, 4 slots.
        run_to(5);
        offer(0, 40, 3);
        measure_frame("clamp_frame", 256);

        // Randomized en and config traffic.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 299) == 0) bus.en = !bus.en;
            bus.cfg_valid     = ($urandom_range(0, 59) == 0);
            bus.cfg_div       = 8'($urandom_range(0, 3));
            bus.cfg_slot_bits = 6'($urandom_range(0, 63));
            bus.cfg_slots     = 4'($urandom_range(0, 15));
            step();
        end
        bus.cfg_valid = 1'b0;
        bus.en = 1'b1;

        // Asynchronous reset mid-slot, then restart on reset defaults.
        repeat (50) step();
        #2 rst_ = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_ready", bus.cfg_ready, 1);
        @(posedge mclk);
        @(negedge mclk);
        compare_all();
        rst_ = 1'b1;
        measure_frame("reset_frame", 512);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
